// File: rtl/fw_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fw_hazard_unit_pkg
// Description : Shared types and constants for the forwarding/hazard unit.
//               Operand selector encoding: 0 = register file, k = forwarding
//               stage k (1 = youngest), n+1 = long-latency completion bus.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package fw_hazard_unit_pkg;

    // Architectural register address width (32 registers).
    localparam int REG_ADDR_W = 5;

    // Largest forwarding depth the selector encoding is sized for.
    localparam int MAX_FW_STAGES = 4;

    // Selector width covers regfile, every stage and the completion bus.
    localparam int FW_SEL_W = $clog2(MAX_FW_STAGES + 2);

    typedef logic [REG_ADDR_W-1:0] regaddr_t;
    typedef logic [FW_SEL_W-1:0]   fw_sel_t;

    // Operand comes from the register file.
    localparam fw_sel_t FW_SEL_RF = '0;

    // Operand comes from the completion bus, which sits one past the oldest
    // forwarding stage of an n-stage configuration.
    function automatic fw_sel_t FW_SEL_LLC(input int unsigned n);
        return fw_sel_t'(n + 1);
    endfunction

endpackage : fw_hazard_unit_pkg
`default_nettype wire

// File: rtl/fw_hazard_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fw_scoreboard
// Description : Tracks destination registers of in-flight long-latency
//               operations (loads, mul/div). Allocates on issue, clears on
//               completion, blocks issue when full or on a WAW conflict, and
//               answers pending/completing lookups for each source operand.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fw_scoreboard
    import fw_hazard_unit_pkg::*;
#(
    parameter int SB_DEPTH    = 4,
    parameter int NUM_SRC     = 2,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    // issue side
    input  logic                     lli_valid,
    input  regaddr_t                 lli_rd_addr,
    output logic                     lli_ready,
    // completion side
    input  logic                     llc_valid,
    input  regaddr_t                 llc_rd_addr,
    // per-source lookup
    input  regaddr_t [NUM_SRC-1:0]   lkp_addr,
    output logic     [NUM_SRC-1:0]   lkp_pending,
    output logic     [NUM_SRC-1:0]   lkp_completing
);

    logic     [SB_DEPTH-1:0] valid_q, valid_d;
    regaddr_t [SB_DEPTH-1:0] addr_q,  addr_d;

    logic [SB_DEPTH-1:0] w_clr_hit;        // entries matching the completion
    logic [SB_DEPTH-1:0] w_clr_one;        // lowest of those, the one cleared
    logic [SB_DEPTH-1:0] w_iss_hit;        // entries matching the issue addr
    logic                w_iss_zero;
    logic                w_iss_pending;
    logic                w_iss_completing;
    logic                w_full;
    logic                w_alloc;
    logic                w_alloc_done;

    // Per-entry address comparison against the issue and completion buses.
    always_comb begin
        w_clr_hit = '0;
        w_iss_hit = '0;
        for (int j = 0; j < SB_DEPTH; j++) begin
            w_clr_hit[j] = valid_q[j] && llc_valid && (addr_q[j] == llc_rd_addr);
            w_iss_hit[j] = valid_q[j] && (addr_q[j] == lli_rd_addr);
        end
        // WAW blocking keeps addresses unique; isolating the lowest hit keeps
        // the clear to a single entry regardless.
        w_clr_one = w_clr_hit & (~w_clr_hit + SB_DEPTH'(1));
    end

    // Issue acceptance. A pending destination is only re-issuable in the
    // cycle it completes, which also frees its slot even when full.
    always_comb begin
        w_iss_zero       = ZERO_REG_EN && (lli_rd_addr == '0);
        w_iss_pending    = |w_iss_hit;
        w_iss_completing = w_iss_pending && llc_valid && (llc_rd_addr == lli_rd_addr);
        w_full           = &valid_q;
        if (w_iss_zero) begin
            lli_ready = 1'b1;
        end else if (w_iss_pending) begin
            lli_ready = w_iss_completing;
        end else begin
            lli_ready = !w_full;
        end
        w_alloc = lli_valid && lli_ready && !w_iss_zero;
    end

    // Next entry state: completion clears first, then issue takes the
    // lowest-index free slot of the post-clear vector.
    always_comb begin
        valid_d      = valid_q & ~w_clr_one;
        addr_d       = addr_q;
        w_alloc_done = 1'b0;
        for (int j = 0; j < SB_DEPTH; j++) begin
            if (w_alloc && !w_alloc_done && !valid_d[j]) begin
                valid_d[j]   = 1'b1;
                addr_d[j]    = lli_rd_addr;
                w_alloc_done = 1'b1;
            end
        end
    end

    // Entry storage; reset empties the scoreboard immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    // Source lookups: is the operand pending, and is it completing right now.
    always_comb begin
        lkp_pending    = '0;
        lkp_completing = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < SB_DEPTH; j++) begin
                if (valid_q[j] && (addr_q[j] == lkp_addr[i])) begin
                    lkp_pending[i] = 1'b1;
                end
            end
            lkp_completing[i] = lkp_pending[i] && llc_valid && (llc_rd_addr == lkp_addr[i]);
        end
    end

endmodule : fw_scoreboard
`default_nettype wire

// File: rtl/fw_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fw_hazard_unit
// Description : Operand forwarding and hazard detection beside ID/EX. For each
//               source operand selects the youngest ready producer among the
//               forwarding stages, the long-latency completion bus, or the
//               register file, raises stall on load-use / long-latency
//               hazards, and counts stalled cycles (saturating).
//               Stage arrays are indexed from 0: element 0 is stage 1
//               (EX/MEM, youngest). NUM_FW_STAGES must not exceed
//               MAX_FW_STAGES so the selector encoding fits.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fw_hazard_unit
    import fw_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int NUM_FW_STAGES = 2,
    parameter int SB_DEPTH      = 4,
    parameter bit ZERO_REG_EN   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  regaddr_t [NUM_SRC-1:0]         src_addr,
    input  logic     [NUM_SRC-1:0]         src_used,
    input  regaddr_t [NUM_FW_STAGES-1:0]   stg_rd_addr,
    input  logic     [NUM_FW_STAGES-1:0]   stg_rd_we,
    input  logic     [NUM_FW_STAGES-1:0]   stg_rd_rdy,
    input  logic                           lli_valid,
    input  regaddr_t                       lli_rd_addr,
    output logic                           lli_ready,
    input  logic                           llc_valid,
    input  regaddr_t                       llc_rd_addr,
    output fw_sel_t  [NUM_SRC-1:0]         src_sel,
    output logic                           stall,
    output logic     [31:0]                stall_cnt
);

    logic [NUM_SRC-1:0] w_src_live;        // operand read and not hard-wired zero
    logic [NUM_SRC-1:0] w_lkp_pending;
    logic [NUM_SRC-1:0] w_lkp_completing;
    logic [NUM_SRC-1:0] w_stg_found;
    logic [NUM_SRC-1:0] w_src_hazard;

    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Register 0 never forwards or stalls when it is hard-wired.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_live
            assign w_src_live[gi] = src_used[gi] &&
                                    !(ZERO_REG_EN && (src_addr[gi] == '0));
        end
    endgenerate

    fw_scoreboard #(
        .SB_DEPTH    (SB_DEPTH),
        .NUM_SRC     (NUM_SRC),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .lli_valid      (lli_valid),
        .lli_rd_addr    (lli_rd_addr),
        .lli_ready      (lli_ready),
        .llc_valid      (llc_valid),
        .llc_rd_addr    (llc_rd_addr),
        .lkp_addr       (src_addr),
        .lkp_pending    (w_lkp_pending),
        .lkp_completing (w_lkp_completing)
    );

    // Per operand: first writing stage wins (ready -> forward, not ready ->
    // load-use hazard); otherwise fall back to the scoreboard, bypassing from
    // the completion bus in the completion cycle.
    always_comb begin
        src_sel      = '0;
        w_stg_found  = '0;
        w_src_hazard = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_sel[i] = FW_SEL_RF;
            for (int k = 0; k < NUM_FW_STAGES; k++) begin
                if (!w_stg_found[i] && w_src_live[i] && stg_rd_we[k] &&
                    (stg_rd_addr[k] == src_addr[i])) begin
                    w_stg_found[i] = 1'b1;
                    if (stg_rd_rdy[k]) begin
                        src_sel[i] = fw_sel_t'(k + 1);
                    end else begin
                        w_src_hazard[i] = 1'b1;
                    end
                end
            end
            if (!w_stg_found[i] && w_src_live[i] && w_lkp_pending[i]) begin
                if (w_lkp_completing[i]) begin
                    src_sel[i] = FW_SEL_LLC(NUM_FW_STAGES);
                end else begin
                    w_src_hazard[i] = 1'b1;
                end
            end
        end
    end

    assign stall = |w_src_hazard;

    // Stalled-cycle counter, holding at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter register; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule : fw_hazard_unit
`default_nettype wire
